// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared CPU defines: HI/LO unit op codes, default latencies, state and result types
//
// Purpose : md_op encodings used by the control decoder and the multiply/divide
//           unit, default cycle counts, FSM state type and the result bundle.
// Ports   : none (package)
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NONE  = 3'd6
  } md_op_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // wr is clear when the result must not reach HI/LO (division by zero).
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } md_res_t;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MIPS-style multiply/divide unit with HI/LO registers
//
// Purpose : mult/multu/div/divu with fixed latency, plus mthi/mtlo writes.
// Ports   : clk, reset_n (async, active-low)
//           Start  - one-cycle request for md_op 0..3
//           md_op  - operation code (see muldiv_unit_pkg)
//           D1, D2 - operands (rs, rt); mthi/mtlo use D1
//           Busy   - operation in flight
//           HI, LO - architectural result registers
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [2:0]  md_op,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  // Whole result is computed when the op is accepted, so later operand
  // changes cannot leak in; the countdown only models latency.
  function automatic md_res_t md_compute(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    md_res_t     r;
    logic [63:0] p;
    logic [31:0] ma, mb, q, m;
    r  = '0;
    p  = '0;
    ma = a[31] ? -a : a;
    mb = b[31] ? -b : b;
    q  = '0;
    m  = '0;
    case (op)
      MD_MULT: begin
        p    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
        r.wr = 1'b1;
      end
      MD_MULTU: begin
        p    = {32'd0, a} * {32'd0, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
        r.wr = 1'b1;
      end
      MD_DIV: if (b != 32'd0) begin
        // Magnitude divide then re-sign: truncation toward zero, remainder
        // follows the dividend; 0x80000000 / -1 falls out as 0x80000000 r 0.
        q    = ma / mb;
        m    = ma % mb;
        r.lo = (a[31] ^ b[31]) ? -q : q;
        r.hi = a[31] ? -m : m;
        r.wr = 1'b1;
      end
      MD_DIVU: if (b != 32'd0) begin
        r.lo = a / b;
        r.hi = a % b;
        r.wr = 1'b1;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  md_state_e   state;
  logic [CW-1:0] cnt;
  logic [31:0] hi_tmp, lo_tmp;
  logic        wr_pend;
  md_res_t     res;
  logic        is_arith, is_div;

  always_comb begin
    res      = md_compute(md_op, D1, D2);
    is_arith = (md_op <= MD_DIVU);
    is_div   = (md_op == MD_DIV) || (md_op == MD_DIVU);
  end

  assign Busy = (state == MD_BUSY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      HI      <= '0;
      LO      <= '0;
      hi_tmp  <= '0;
      lo_tmp  <= '0;
      wr_pend <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (Start && is_arith) begin
            hi_tmp  <= res.hi;
            lo_tmp  <= res.lo;
            wr_pend <= res.wr;
            cnt     <= is_div ? DIV_LOAD : MULT_LOAD;
            state   <= MD_BUSY;
          end else if (md_op == MD_MTHI) begin
            HI <= D1;
          end else if (md_op == MD_MTLO) begin
            LO <= D1;
          end
        end
        MD_BUSY: begin
          // cnt reaches 0 on this edge: retire the result and go idle.
          if (cnt <= CW'(1)) begin
            cnt   <= '0;
            state <= MD_IDLE;
            if (wr_pend) begin
              HI <= hi_tmp;
              LO <= lo_tmp;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL provide parameter MULT_CYCLES, default 5, giving the busy cycles per mult/multu.
REQ-002 The block SHALL provide parameter DIV_CYCLES, default 10, giving the busy cycles per div/divu.
REQ-003 The block SHALL provide port clk, input, 1 bit, the single rising-edge clock.
REQ-004 The block SHALL provide port reset_n, input, 1 bit, the reset: asynchronous and active-low.
REQ-005 The block SHALL provide port Start, input, 1 bit, a one-cycle request to begin mult/multu/div/divu.
REQ-006 The block SHALL provide port md_op, input, 3 bits, the operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 none.
REQ-007 The block SHALL provide ports D1 and D2, inputs, 32 bits each, the operands (rs, rt); mthi/mtlo take D1.
REQ-008 The block SHALL provide port Busy, output, 1 bit, high while an operation is in flight.
REQ-009 The block SHALL provide ports HI and LO, outputs, 32 bits each, the architectural HI/LO registers.

Function
REQ-010 The FSM SHALL have exactly two states, IDLE and BUSY, plus a down-counter cnt with width clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
REQ-011 In IDLE, a rising edge with Start=1 and md_op in 0..3 SHALL latch the operands, compute the result into internal hi_tmp/lo_tmp, load cnt with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-012 Busy SHALL equal (state==BUSY), so it is high for exactly N consecutive cycles starting the cycle after Start (N = MULT_CYCLES or DIV_CYCLES).
REQ-013 HI/LO SHALL update from hi_tmp/lo_tmp on the edge where cnt reaches 0; on that same edge the state SHALL return to IDLE and Busy SHALL drop.
REQ-014 mult SHALL produce a signed 64-bit product and multu an unsigned one, with {HI,LO} = the product.
REQ-015 div/divu SHALL produce LO = quotient and HI = remainder; the quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-016 Division by zero SHALL still run DIV_CYCLES cycles but leave HI and LO unchanged.
REQ-017 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0x00000000.
REQ-018 In IDLE, md_op=4 (mthi) SHALL write HI=D1 and md_op=5 (mtlo) SHALL write LO=D1 on the next edge, with no Busy; these writes SHALL NOT require Start.
REQ-019 Start, mthi and mtlo arriving while Busy=1 SHALL be ignored; the decode/hazard unit stalls on (Start | Busy).
REQ-020 Start with md_op of 4..7 SHALL be treated as no operation.
REQ-021 HI/LO SHALL hold their value at all times other than REQ-013 and REQ-018.
REQ-022 Operand changes on D1/D2 during BUSY SHALL NOT affect the result.

Reset
REQ-023 Asserting reset_n=0 SHALL immediately force state=IDLE, cnt=0, Busy=0, HI=0 and LO=0, independent of clk.
REQ-024 Reset during BUSY SHALL abort the operation and discard the pending result; the first edge after release SHALL behave as IDLE.

Structure
REQ-025 The md_op encodings (MD_MULT..MD_NONE) and the default cycle counts SHALL live in the shared CPU defines package used by the control decoder.
REQ-026 The block SHALL be a single module with no sub-module; a combinational result-compute function inside the module is permitted.

Verification
REQ-027 Verify mult: D1=0xFFFFFFFE (-2), D2=3, md_op=0, Start -> Busy high 5 cycles -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-028 Verify multu: D1=0xFFFFFFFF, D2=2, md_op=1, Start -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-029 Verify div: D1=0xFFFFFFF9 (-7), D2=2, md_op=2, Start -> Busy high 10 cycles -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then divu with D2=0 -> Busy 10 cycles, HI/LO unchanged.
REQ-030 Verify mthi/mtlo: md_op=4, D1=0x12345678 -> HI=0x12345678 next edge, Busy=0; then md_op=5 while Busy after a mult -> LO keeps the mult result.
REQ-031 Verify Start during BUSY: a second Start at busy cycle 3 -> ignored, Busy still drops after the original 5 cycles, and the result is from the first op.
REQ-032 Verify reset mid-op: reset_n pulsed low at div busy cycle 4 -> Busy, HI and LO are 0 immediately, and no later write occurs.
